// File: rtl/dsp_mac_sequencer.sv
// Sequencer for DSP48A1 pipeline-register enables: walks each accepted operand beat
// through the A/B -> M -> P stages of an N-term multiply-accumulate job.
module dsp_mac_sequencer #(
    parameter int          CNT_W      = 8,
    parameter int          PIPE_LAT   = 3,
    parameter logic [7:0]  ACC_OPMODE = 8'h09
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [CNT_W-1:0] start_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic             abort,
    output logic             ce_ab,
    output logic             ce_m,
    output logic             ce_p,
    output logic             rst_p,
    output logic [7:0]       opmode,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   remaining_r;
    logic [CNT_W-1:0]   remaining_s;
    logic [PIPE_LAT-2:0] tok_r;
    logic               accept_s;
    logic               drain_last_s;

    // The last token is at the P stage with nothing left behind it in the pipe.
    assign drain_last_s = tok_r[PIPE_LAT-2] && (tok_r[PIPE_LAT-3:0] == {(PIPE_LAT-2){1'b0}});

    // State and remaining-beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            remaining_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            remaining_r <= remaining_s;
        end
    end

    // Token pipe: one bit per accepted beat, delayed to time the M and P enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_r <= {(PIPE_LAT-1){1'b0}};
        end else if (abort && (state_r != S_IDLE)) begin
            tok_r <= {(PIPE_LAT-1){1'b0}};
        end else begin
            tok_r <= {tok_r[PIPE_LAT-3:0], accept_s};
        end
    end

    // Next-state, counter update and handshake decode.
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        op_ready    = 1'b0;
        accept_s    = 1'b0;
        rst_p       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start_valid) begin
                    remaining_s = start_len;
                    state_s     = S_CLEAR;
                end else begin
                    state_s     = S_IDLE;
                end
            end
            S_CLEAR: begin
                rst_p = 1'b1;
                if (abort) begin
                    state_s     = S_IDLE;
                    remaining_s = {CNT_W{1'b0}};
                end else if (remaining_r == {CNT_W{1'b0}}) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_FEED;
                end
            end
            S_FEED: begin
                op_ready = !abort;
                accept_s = op_valid && !abort;
                if (abort) begin
                    state_s     = S_IDLE;
                    remaining_s = {CNT_W{1'b0}};
                end else if (accept_s) begin
                    // Saturating decrement keeps the counter from wrapping.
                    if (remaining_r != {CNT_W{1'b0}}) begin
                        remaining_s = remaining_r - CNT_W'(1);
                    end else begin
                        remaining_s = remaining_r;
                    end
                    if (remaining_r == CNT_W'(1)) begin
                        state_s = S_DRAIN;
                    end else begin
                        state_s = S_FEED;
                    end
                end else begin
                    state_s = S_FEED;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_s     = S_IDLE;
                    remaining_s = {CNT_W{1'b0}};
                end else if (drain_last_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_DONE: begin
                state_s     = S_IDLE;
                remaining_s = {CNT_W{1'b0}};
            end
            default: begin
                state_s     = S_IDLE;
                remaining_s = {CNT_W{1'b0}};
            end
        endcase
    end

    assign ce_ab       = accept_s;
    assign ce_m        = tok_r[0];
    assign ce_p        = tok_r[PIPE_LAT-2];
    assign busy        = (state_r != S_IDLE);
    assign done        = (state_r == S_DONE);
    assign start_ready = (state_r == S_IDLE);
    assign opmode      = busy ? ACC_OPMODE : 8'h00;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer: per-job enable timing, zero-length jobs,
// abort, asynchronous reset and back-to-back start handling.
module tb_dsp_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] start_len;
    logic       op_valid;
    logic       op_ready;
    logic       abort;
    logic       ce_ab;
    logic       ce_m;
    logic       ce_p;
    logic       rst_p;
    logic [7:0] opmode;
    logic       busy;
    logic       done;

    int tests_run  = 0;
    int tests_fail = 0;

    // Statistics of the most recent job, cycle 0 = start handshake.
    int n_ab, n_m, n_p, n_rstp, n_done, n_late;
    int first_ab, last_ab, first_p, last_p, done_cyc, busy_after;
    bit timed_out;

    dsp_mac_sequencer #(.CNT_W(8), .PIPE_LAT(3), .ACC_OPMODE(8'h09)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready), .start_len(start_len),
        .op_valid(op_valid), .op_ready(op_ready), .abort(abort),
        .ce_ab(ce_ab), .ce_m(ce_m), .ce_p(ce_p), .rst_p(rst_p),
        .opmode(opmode), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one job; op_valid follows vpat from the first FEED cycle (cycle 2), then stays high.
    task automatic run_job(input int len, input logic [7:0] vpat, input int plen,
                           input int abort_at, input int max_cyc);
        int  idx;
        int  abort_cyc;
        bit  ended;
        n_ab = 0; n_m = 0; n_p = 0; n_rstp = 0; n_done = 0; n_late = 0;
        first_ab = -1; last_ab = -1; first_p = -1; last_p = -1;
        done_cyc = -1; busy_after = -1; abort_cyc = -1; ended = 1'b0; timed_out = 1'b0;
        @(negedge clk);
        start_valid = 1'b1; start_len = len[7:0]; op_valid = 1'b0; abort = 1'b0;
        #1;
        check_eq("start_ready_at_handshake", start_ready, 1);
        for (int cyc = 1; cyc <= max_cyc && !ended; cyc++) begin
            @(negedge clk);
            start_valid = 1'b0;
            idx = cyc - 2;
            if (idx < 0)         op_valid = 1'b0;
            else if (idx < plen) op_valid = vpat[idx];
            else                 op_valid = 1'b1;
            abort = (abort_at >= 0) && (abort_cyc < 0) && (n_ab == abort_at);
            if (abort) abort_cyc = cyc;
            #1;
            if (ce_ab) begin n_ab++; if (first_ab < 0) first_ab = cyc; last_ab = cyc; end
            if (ce_m) n_m++;
            if (ce_p) begin n_p++; if (first_p < 0) first_p = cyc; last_p = cyc; end
            if (rst_p) n_rstp++;
            if (done) begin n_done++; done_cyc = cyc; end
            if (abort) begin
                check_eq("abort_op_ready", op_ready, 0);
                check_eq("abort_ce_ab", ce_ab, 0);
            end
            if (abort_cyc >= 0 && cyc > abort_cyc && (ce_m || ce_p)) n_late++;
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) check_eq("abort_idle_next", busy, 0);
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin busy_after = busy; ended = 1'b1; end
            if (abort_cyc >= 0 && cyc == abort_cyc + 4) ended = 1'b1;
        end
        if (!ended) begin
            timed_out = 1'b1;
            check_eq("job_timeout", 1, 0);
        end
        abort = 1'b0; op_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; start_len = 8'd0; op_valid = 1'b0; abort = 1'b0;
        #2;
        check_eq("rst_start_ready", start_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_opmode", opmode, 0);
        check_eq("rst_enables", {ce_ab, ce_m, ce_p, rst_p, op_ready, done}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // 1: len=4, op_valid held high.
        run_job(4, 8'h00, 0, -1, 40);
        check_eq("t1_n_ab", n_ab, 4);
        check_eq("t1_first_ab", first_ab, 2);
        check_eq("t1_last_ab", last_ab, 5);
        check_eq("t1_n_m", n_m, 4);
        check_eq("t1_first_p", first_p, 4);
        check_eq("t1_last_p", last_p, 7);
        check_eq("t1_n_p", n_p, 4);
        check_eq("t1_rstp", n_rstp, 1);
        check_eq("t1_done_cyc", done_cyc, 8);
        check_eq("t1_n_done", n_done, 1);
        check_eq("t1_busy_after", busy_after, 0);

        // 2: len=3 with stalls 1,0,0,1,0,1 -> accepts at 2,5,7.
        run_job(3, 8'b0010_1001, 6, -1, 40);
        check_eq("t2_n_ab", n_ab, 3);
        check_eq("t2_last_ab", last_ab, 7);
        check_eq("t2_n_p", n_p, 3);
        check_eq("t2_last_p", last_p, 9);
        check_eq("t2_done_cyc", done_cyc, 10);

        // 3: len=0 -> clear then done, no enables.
        run_job(0, 8'h00, 0, -1, 20);
        check_eq("t3_rstp", n_rstp, 1);
        check_eq("t3_done_cyc", done_cyc, 2);
        check_eq("t3_enables", n_ab + n_m + n_p, 0);

        // 4: len=5, abort after 2 accepts.
        run_job(5, 8'h00, 0, 2, 20);
        check_eq("t4_n_ab", n_ab, 2);
        check_eq("t4_n_done", n_done, 0);
        check_eq("t4_late_tokens", n_late, 0);

        // 5: asynchronous reset between edges mid-FEED.
        @(negedge clk);
        start_valid = 1'b1; start_len = 8'd5;
        @(negedge clk);
        start_valid = 1'b0; op_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        check_eq("t5_feeding", ce_ab, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_busy", busy, 0);
        check_eq("t5_enables", {ce_ab, ce_m, ce_p, rst_p, op_ready, done}, 0);
        check_eq("t5_opmode", opmode, 0);
        check_eq("t5_start_ready", start_ready, 1);
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("t5_ready_after_release", start_ready, 1);

        // 6: start_valid held through DONE of a len=1 job, then a len=255 job.
        begin
            int got_done;
            got_done = -1;
            @(negedge clk);
            start_valid = 1'b1; start_len = 8'd1; op_valid = 1'b1;
            for (int cyc = 1; cyc <= 10 && got_done < 0; cyc++) begin
                @(negedge clk);
                start_len = 8'd255;
                #1;
                if (done) begin
                    got_done = cyc;
                    check_eq("t6_ready_in_done", start_ready, 0);
                    check_eq("t6_busy_in_done", busy, 1);
                end
            end
            check_eq("t6_first_done_cyc", got_done, 5);
        end
        run_job(255, 8'h00, 0, -1, 300);
        check_eq("t6_n_ab", n_ab, 255);
        check_eq("t6_done_cyc", done_cyc, 259);
        check_eq("t6_n_done", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
